load_store_unit: RTL and testbench

//  Execute-stage consumer of the IALU result. IALU output (rs1+imm) is the effective address.

---
 rtl/load_store_unit_if.sv | 65 ++++++
 rtl/load_store_unit.sv | 206 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
//   Bundles the core-side request/response signals and the data-memory
//   req/gnt/rvalid port of the load/store unit.
//
//   Handshake semantics:
//     core side   : an op is accepted on a rising edge where i_valid & o_ready.
//                   The result arrives as a one-cycle o_done pulse, with
//                   o_rdata/o_misaligned valid in that same cycle.
//     memory side : a request is accepted on a rising edge where
//                   o_mem_req & i_mem_gnt. Until then o_mem_addr, o_mem_we,
//                   o_mem_be and o_mem_wdata stay stable. Read data is taken
//                   on any edge with i_mem_rvalid high while a load is in flight.
//
//   Modports:
//     slave  - the load/store unit (consumes i_*, drives o_* and dbg_state)
//     master - the environment: the EX stage and the data memory
//
//   Signals:
//     i_valid, o_ready             op request / unit idle
//     i_addr, i_wdata              effective address, store data (rs2)
//     i_funct3, i_store            RV32I funct3, 1=store 0=load
//     o_mem_req, o_mem_we          memory request, write enable
//     o_mem_addr, o_mem_wdata      word-aligned address, lane-replicated data
//     o_mem_be                     byte enables
//     i_mem_gnt, i_mem_rvalid      request accepted, read data valid
//     i_mem_rdata                  read data word
//     o_done, o_rdata              completion pulse, extended load result
//     o_misaligned                 trap flag, valid with o_done
//     dbg_state                    FSM state (0=IDLE, 1=REQ, 2=WAIT)
// ---------------------------------------------------------------------------
interface load_store_unit_if;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [2:0]  i_funct3;
    logic        i_store;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_be;
    logic        i_mem_gnt;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;
    logic        o_done;
    logic [31:0] o_rdata;
    logic        o_misaligned;
    logic [1:0]  dbg_state;

    modport slave (
        input  i_valid, i_addr, i_wdata, i_funct3, i_store,
        input  i_mem_gnt, i_mem_rvalid, i_mem_rdata,
        output o_ready, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
        output o_done, o_rdata, o_misaligned, dbg_state
    );

    modport master (
        output i_valid, i_addr, i_wdata, i_funct3, i_store,
        output i_mem_gnt, i_mem_rvalid, i_mem_rdata,
        input  o_ready, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
        input  o_done, o_rdata, o_misaligned, dbg_state
    );
endinterface

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Execute-stage RV32I load/store unit. The IALU result (rs1+imm) arrives
//   as the effective address. The unit performs LB/LH/LW/LBU/LHU/SB/SH/SW
//   over a req/gnt/rvalid data-memory port. It steers byte lanes, generates
//   byte enables, sign/zero-extends loads and flags misaligned or illegal
//   ops. The core stalls while o_ready is low.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    load_store_unit_if.slave (core request/response + memory port)
//
//   FSM: IDLE -> REQ (memory request held until gnt) -> WAIT (load data).
//   All outputs are registered. The minimum accept->o_done latency is
//   2 cycles with a zero-wait memory.
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    load_store_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Op context latched at accept
    logic [1:0]      lane_q;
    logic [2:0]      funct3_q;
    logic            store_q;

    // Registered outputs
    logic            mem_req_q;
    logic            mem_we_q;
    logic [XLEN-1:0] mem_addr_q;
    logic [XLEN-1:0] mem_wdata_q;
    logic [3:0]      mem_be_q;
    logic            done_q;
    logic            misaligned_q;
    logic [XLEN-1:0] rdata_q;

    // Control decode
    logic            accept;
    logic            illegal;
    logic            go_legal;
    logic            go_illegal;
    logic            gnt_now;
    logic            load_done;
    logic            store_done;

    // Datapath
    logic [XLEN-1:0] req_wdata;
    logic [3:0]      req_be;
    logic [7:0]      lane_byte;
    logic [15:0]     lane_half;
    logic [XLEN-1:0] load_result;

    assign accept     = bus.i_valid && (state_q == S_IDLE);
    assign go_legal   = accept && !illegal;
    assign go_illegal = accept && illegal;
    assign gnt_now    = (state_q == S_REQ) && bus.i_mem_gnt;
    assign store_done = gnt_now && store_q;
    // A grant and rvalid arriving together skip the WAIT state entirely.
    assign load_done  = (gnt_now && !store_q && bus.i_mem_rvalid) ||
                        ((state_q == S_WAIT) && bus.i_mem_rvalid);

    // Illegal encodings and misalignment both end in the same trap. The
    // access size is funct3[1:0] for loads and stores alike.
    always_comb begin
        illegal = 1'b0;
        if (bus.i_store) begin
            if (bus.i_funct3 > 3'b010) illegal = 1'b1;
        end else begin
            if ((bus.i_funct3 == 3'b011) || (bus.i_funct3[2:1] == 2'b11)) illegal = 1'b1;
        end
        case (bus.i_funct3[1:0])
            2'b01:   if (bus.i_addr[0]) illegal = 1'b1;
            2'b10:   if (bus.i_addr[1:0] != 2'b00) illegal = 1'b1;
            default: ;
        endcase
    end

    // Store data is replicated across all lanes so memory only has to honour
    // the byte enables. Loads always read the full word.
    always_comb begin
        req_wdata = '0;
        req_be    = 4'b1111;
        if (bus.i_store) begin
            case (bus.i_funct3[1:0])
                2'b00: begin
                    req_wdata = {4{bus.i_wdata[7:0]}};
                    req_be    = 4'b0001 << bus.i_addr[1:0];
                end
                2'b01: begin
                    req_wdata = {2{bus.i_wdata[15:0]}};
                    req_be    = 4'b0011 << {bus.i_addr[1], 1'b0};
                end
                default: begin
                    req_wdata = bus.i_wdata;
                    req_be    = 4'b1111;
                end
            endcase
        end
    end

    // Lane extraction and extension of the returned word
    always_comb begin
        lane_byte = bus.i_mem_rdata[7:0];
        case (lane_q)
            2'b01:   lane_byte = bus.i_mem_rdata[15:8];
            2'b10:   lane_byte = bus.i_mem_rdata[23:16];
            2'b11:   lane_byte = bus.i_mem_rdata[31:24];
            default: lane_byte = bus.i_mem_rdata[7:0];
        endcase
        lane_half = lane_q[1] ? bus.i_mem_rdata[31:16] : bus.i_mem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_result = {{(XLEN-8){lane_byte[7]}}, lane_byte};
            3'b001:  load_result = {{(XLEN-16){lane_half[15]}}, lane_half};
            3'b100:  load_result = {{(XLEN-8){1'b0}}, lane_byte};
            3'b101:  load_result = {{(XLEN-16){1'b0}}, lane_half};
            default: load_result = bus.i_mem_rdata;
        endcase
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (go_legal) state_d = S_REQ;
            S_REQ: begin
                if (bus.i_mem_gnt) begin
                    if (store_q || bus.i_mem_rvalid) state_d = S_IDLE;
                    else                             state_d = S_WAIT;
                end
            end
            S_WAIT:  if (bus.i_mem_rvalid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q       <= 2'b00;
            funct3_q     <= 3'b000;
            store_q      <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= 4'b0000;
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
            rdata_q      <= '0;
        end else begin
            if (accept) begin
                lane_q   <= bus.i_addr[1:0];
                funct3_q <= bus.i_funct3;
                store_q  <= bus.i_store;
            end

            // Request fields stay frozen from accept until the grant edge.
            if (go_legal) begin
                mem_req_q   <= 1'b1;
                mem_we_q    <= bus.i_store;
                mem_addr_q  <= {bus.i_addr[XLEN-1:2], 2'b00};
                mem_wdata_q <= req_wdata;
                mem_be_q    <= req_be;
            end else if (gnt_now) begin
                mem_req_q   <= 1'b0;
                mem_we_q    <= 1'b0;
                mem_wdata_q <= '0;
                mem_be_q    <= 4'b0000;
            end

            done_q       <= go_illegal || store_done || load_done;
            misaligned_q <= go_illegal;
            if (load_done) rdata_q <= load_result;
        end
    end

    assign bus.o_ready      = (state_q == S_IDLE);
    assign bus.o_mem_req    = mem_req_q;
    assign bus.o_mem_we     = mem_we_q;
    assign bus.o_mem_addr   = mem_addr_q;
    assign bus.o_mem_wdata  = mem_wdata_q;
    assign bus.o_mem_be     = mem_be_q;
    assign bus.o_done       = done_q;
    assign bus.o_misaligned = misaligned_q;
    assign bus.o_rdata      = rdata_q;
    assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//   Directed bench for load_store_unit. The driver pushes the expected
//   response {misaligned, rdata}, the expected latency and the expected
//   memory request for each issued op. A response monitor pops one entry on
//   each o_done. The memory model checks each request cycle against the
//   expected memory request, and grants/returns data after a configurable
//   delay.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    load_store_unit_if bus();

    load_store_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- scoreboard state ----------------
    int tests = 0;
    int fails = 0;
    logic [32:0] exp_q[$];   // {misaligned, rdata}
    int          lat_q[$];   // expected accept->done cycles
    int          acc_q[$];   // cycle number of the accept cycle
    logic [69:0] mem_q[$];   // {check_wdata, we, be, addr, wdata}
    int done_cnt = 0;
    int req_cnt  = 0;

    // memory model configuration
    int          gnt_delay = 0;
    int          rv_delay  = 0;
    logic [31:0] mem_word  = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [69:0] mk_mem(input logic chk_wd, input logic we,
                                           input logic [3:0] be, input logic [31:0] addr,
                                           input logic [31:0] wd);
        return {chk_wd, we, be, addr, wd};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [32:0] exp, input int lat,
                         input logic legal, input logic [69:0] mexp);
        int g;
        g = 0;
        @(negedge clk);
        while (!bus.o_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) begin
            tests++;
            fails++;
            $display("FAIL issue_timeout: got o_ready=0 for 100 cycles expected 1");
            return;
        end
        bus.i_valid  = 1'b1;
        bus.i_store  = st;
        bus.i_funct3 = f3;
        bus.i_addr   = a;
        bus.i_wdata  = wd;
        acc_q.push_back(cyc);
        @(posedge clk);
        #1;
        exp_q.push_back(exp);
        lat_q.push_back(lat);
        if (legal) mem_q.push_back(mexp);
        bus.i_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("drain_pending", exp_q.size(), 0);
        @(negedge clk);
    endtask

    // ---------------- response monitor ----------------
    initial begin
        logic [32:0] e;
        int l;
        int a;
        forever begin
            @(negedge clk);
            if (rst_n && bus.o_done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got o_done=1 expected no completion (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    l = lat_q.pop_front();
                    a = acc_q.pop_front();
                    check("resp_misaligned_rdata", {bus.o_misaligned, bus.o_rdata}, e);
                    check("latency", cyc - a, l);
                end
            end
        end
    end

    // ---------------- memory model + request checker ----------------
    initial begin
        logic [69:0] m;
        int wait_n;
        int pend;
        wait_n = 0;
        pend   = 0;
        bus.i_mem_gnt    = 1'b0;
        bus.i_mem_rvalid = 1'b0;
        bus.i_mem_rdata  = '0;
        forever begin
            @(negedge clk);
            bus.i_mem_gnt    = 1'b0;
            bus.i_mem_rvalid = 1'b0;
            bus.i_mem_rdata  = $urandom();
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus.i_mem_rvalid = 1'b1;
                    bus.i_mem_rdata  = mem_word;
                end
            end
            if (rst_n && bus.o_mem_req) begin
                req_cnt++;
                if (mem_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_req: got o_mem_req=1 expected 0 (t=%0t)", $time);
                end else begin
                    m = mem_q[0];
                    check("mem_we", bus.o_mem_we, m[68]);
                    check("mem_be", bus.o_mem_be, m[67:64]);
                    check("mem_addr", bus.o_mem_addr, m[63:32]);
                    if (m[69]) check("mem_wdata", bus.o_mem_wdata, m[31:0]);
                end
                if (wait_n >= gnt_delay) begin
                    bus.i_mem_gnt = 1'b1;
                    wait_n = 0;
                    if (mem_q.size() > 0) void'(mem_q.pop_front());
                    if (!bus.o_mem_we) begin
                        if (rv_delay == 0) begin
                            bus.i_mem_rvalid = 1'b1;
                            bus.i_mem_rdata  = mem_word;
                        end else begin
                            pend = rv_delay;
                        end
                    end
                end else begin
                    wait_n++;
                end
            end else begin
                wait_n = 0;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000ns");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int snap;
        bus.i_valid  = 1'b0;
        bus.i_store  = 1'b0;
        bus.i_funct3 = 3'b000;
        bus.i_addr   = '0;
        bus.i_wdata  = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_ready", bus.o_ready, 1);
        check("rst_mem_req", bus.o_mem_req, 0);
        check("rst_mem_we", bus.o_mem_we, 0);
        check("rst_mem_be", bus.o_mem_be, 0);
        check("rst_mem_addr", bus.o_mem_addr, 0);
        check("rst_done", bus.o_done, 0);
        check("rst_rdata", bus.o_rdata, 0);
        check("rst_misaligned", bus.o_misaligned, 0);
        check("rst_state", bus.dbg_state, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // LW zero-wait, gnt&rvalid in REQ
        mem_word = 32'hDEAD_BEEF;
        issue(0, 3'b010, 32'h100, 32'h0, {1'b0, 32'hDEAD_BEEF}, 2, 1,
              mk_mem(0, 0, 4'b1111, 32'h100, 0));
        drain();

        // LB / LBU upper byte
        mem_word = 32'h80FF_0000;
        issue(0, 3'b000, 32'h103, 32'h0, {1'b0, 32'hFFFF_FF80}, 2, 1,
              mk_mem(0, 0, 4'b1111, 32'h100, 0));
        drain();
        issue(0, 3'b100, 32'h103, 32'h0, {1'b0, 32'h0000_0080}, 2, 1,
              mk_mem(0, 0, 4'b1111, 32'h100, 0));
        drain();

        // LH upper half
        mem_word = 32'h8001_1234;
        issue(0, 3'b001, 32'h102, 32'h0, {1'b0, 32'hFFFF_8001}, 2, 1,
              mk_mem(0, 0, 4'b1111, 32'h100, 0));
        drain();

        // LH misaligned: trap, no memory request, rdata unchanged
        snap = req_cnt;
        issue(0, 3'b001, 32'h101, 32'h0, {1'b1, 32'hFFFF_8001}, 1, 0, '0);
        drain();
        check("misaligned_no_req", req_cnt - snap, 0);

        // SB with grant held low 3 cycles
        gnt_delay = 3;
        snap = req_cnt;
        issue(1, 3'b000, 32'h202, 32'h1234_56AB, {1'b0, 32'hFFFF_8001}, 5, 1,
              mk_mem(1, 1, 4'b0100, 32'h200, 32'hABAB_ABAB));
        drain();
        check("sb_req_cycles", req_cnt - snap, 4);
        gnt_delay = 0;

        // SH upper half, with a 1-cycle grant wait
        gnt_delay = 1;
        issue(1, 3'b001, 32'h206, 32'h0000_BEEF, {1'b0, 32'hFFFF_8001}, 3, 1,
              mk_mem(1, 1, 4'b1100, 32'h204, 32'hBEEF_BEEF));
        drain();
        gnt_delay = 0;

        // SW
        issue(1, 3'b010, 32'h208, 32'hCAFE_F00D, {1'b0, 32'hFFFF_8001}, 2, 1,
              mk_mem(1, 1, 4'b1111, 32'h208, 32'hCAFE_F00D));
        drain();

        // LHU lower half through WAIT (rvalid 2 cycles after gnt)
        mem_word = 32'h8001_F234;
        rv_delay = 2;
        issue(0, 3'b101, 32'h100, 32'h0, {1'b0, 32'h0000_F234}, 4, 1,
              mk_mem(0, 0, 4'b1111, 32'h100, 0));
        drain();
        rv_delay = 0;

        // illegal encodings and misaligned word
        issue(0, 3'b011, 32'h100, 32'h0, {1'b1, 32'h0000_F234}, 1, 0, '0);
        drain();
        issue(1, 3'b011, 32'h100, 32'h0, {1'b1, 32'h0000_F234}, 1, 0, '0);
        drain();
        issue(0, 3'b010, 32'h102, 32'h0, {1'b1, 32'h0000_F234}, 1, 0, '0);
        drain();

        // back-to-back loads: second accepted in the o_done cycle of the first
        mem_word = 32'h0000_7F85;
        issue(0, 3'b000, 32'h100, 32'h0, {1'b0, 32'hFFFF_FF85}, 2, 1,
              mk_mem(0, 0, 4'b1111, 32'h100, 0));
        issue(0, 3'b001, 32'h100, 32'h0, {1'b0, 32'h0000_7F85}, 2, 1,
              mk_mem(0, 0, 4'b1111, 32'h100, 0));
        drain();

        // reset while in WAIT
        rv_delay = 6;
        mem_word = 32'h5555_AAAA;
        issue(0, 3'b010, 32'h300, 32'h0, {1'b0, 32'h5555_AAAA}, 8, 1,
              mk_mem(0, 0, 4'b1111, 32'h300, 0));
        @(negedge clk);
        @(negedge clk);
        check("wait_state", bus.dbg_state, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_mem_req", bus.o_mem_req, 0);
        check("rst_mid_ready", bus.o_ready, 1);
        exp_q.delete();
        lat_q.delete();
        acc_q.delete();
        mem_q.delete();
        snap = done_cnt;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("late_rvalid_no_done", done_cnt - snap, 0);
        check("rst_mid_rdata", bus.o_rdata, 0);
        rv_delay = 0;

        // recovery after reset
        mem_word = 32'h0123_4567;
        issue(0, 3'b010, 32'h104, 32'h0, {1'b0, 32'h0123_4567}, 2, 1,
              mk_mem(0, 0, 4'b1111, 32'h104, 0));
        drain();

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
